// File: rtl/fixedpoint_pkg.sv
// Shared definitions for the fixed-point multiplier: rounding-mode encodings,
// the sideband bundle that travels with each beat, and the output range helper.
package fixedpoint_pkg;

    localparam logic [1:0] RND_AWAY  = 2'b00;
    localparam logic [1:0] RND_TRUNC = 2'b01;
    localparam logic [1:0] RND_EVEN  = 2'b10;

    typedef struct packed {
        logic [1:0] mode;
        logic       sat_en;
    } side_t;

    // Largest positive value representable in a w-bit two's complement word.
    function automatic logic signed [63:0] sat_range(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

endpackage

// File: rtl/fixedpoint_round.sv
// Combinational rounding and range stage: full-width signed product in,
// rounded OUT_W result plus overflow flag out.
module fixedpoint_round
    import fixedpoint_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int FRAC_W   = 4,
    parameter int OUT_W    = 8,
    parameter int OUT_FRAC = 0
) (
    input  logic signed [2*IN_W-1:0] product,
    input  logic [1:0]               mode,
    input  logic                     sat_en,
    output logic [OUT_W-1:0]         out,
    output logic                     ovf
);

    localparam int PW = 2 * IN_W;
    localparam int IW = PW + 1;
    localparam int SH = 2 * FRAC_W - OUT_FRAC;
    localparam logic signed [63:0] MAX_V = sat_range(OUT_W);
    localparam logic signed [63:0] MIN_V = -MAX_V - 64'sd1;

    // One guard bit above the product so the +1 of rounding can never wrap.
    logic signed [IW-1:0] rounded;
    logic signed [63:0]   wide;

    generate
        if (SH == 0) begin : g_pass
            assign rounded = {product[PW-1], product};
        end else begin : g_rnd
            localparam logic [SH-1:0] HALF = SH'(1) << (SH - 1);
            logic signed [IW-1:0] ext;
            logic signed [IW-1:0] floor_v;
            logic [SH-1:0]        dropped;
            logic                 tie;
            logic                 above;
            logic                 inc;

            assign ext     = {product[PW-1], product};
            assign floor_v = ext >>> SH;
            assign dropped = ext[SH-1:0];
            assign tie     = (dropped == HALF);
            assign above   = (dropped > HALF);

            // Ties: away-from-zero bumps positives only, since floor already moved negatives away.
            always_comb begin
                inc = 1'b0;
                case (mode)
                    RND_TRUNC: inc = 1'b0;
                    RND_EVEN:  inc = above | (tie & floor_v[0]);
                    default:   inc = above | (tie & ~ext[IW-1]);
                endcase
            end

            assign rounded = floor_v + {{(IW-1){1'b0}}, inc};
        end
    endgenerate

    assign wide = 64'(rounded);

    always_comb begin
        ovf = (wide > MAX_V) || (wide < MIN_V);
        out = wide[OUT_W-1:0];
        if (ovf && sat_en) begin
            out = wide[63] ? MIN_V[OUT_W-1:0] : MAX_V[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/fixedpoint_s_pipe.sv
// Three-stage pipelined signed fixed-point multiplier with per-beat rounding
// mode, saturate/wrap select and valid/ready flow control on both sides.
module fixedpoint_s_pipe
    import fixedpoint_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int FRAC_W   = 4,
    parameter int OUT_W    = 8,
    parameter int OUT_FRAC = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in1,
    input  logic signed [IN_W-1:0]  in2,
    input  logic [1:0]              mode,
    input  logic                    sat_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out,
    output logic                    ovf
);

    localparam int PW = 2 * IN_W;

    logic                   s1_valid;
    logic signed [IN_W-1:0] s1_a;
    logic signed [IN_W-1:0] s1_b;
    side_t                  s1_side;

    logic                   s2_valid;
    logic signed [PW-1:0]   s2_prod;
    side_t                  s2_side;

    logic                   s3_valid;
    logic [OUT_W-1:0]       s3_out;
    logic                   s3_ovf;

    logic                   s1_load;
    logic                   s2_load;
    logic                   s3_load;
    logic [OUT_W-1:0]       rnd_out;
    logic                   rnd_ovf;

    // Load enables ripple back from the output; a stage loads if empty or its successor loads.
    assign s3_load  = !s3_valid || out_ready;
    assign s2_load  = !s2_valid || s3_load;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_side  <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a    <= in1;
                s1_b    <= in2;
                s1_side <= '{mode: mode, sat_en: sat_en};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            s2_side  <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_prod <= PW'(s1_a) * PW'(s1_b);
                s2_side <= s1_side;
            end
        end
    end

    fixedpoint_round #(
        .IN_W     (IN_W),
        .FRAC_W   (FRAC_W),
        .OUT_W    (OUT_W),
        .OUT_FRAC (OUT_FRAC)
    ) u_round (
        .product (s2_prod),
        .mode    (s2_side.mode),
        .sat_en  (s2_side.sat_en),
        .out     (rnd_out),
        .ovf     (rnd_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            s3_out   <= '0;
            s3_ovf   <= 1'b0;
        end else if (s3_load) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_out <= rnd_out;
                s3_ovf <= rnd_ovf;
            end
        end
    end

    assign out_valid = s3_valid;
    assign out       = s3_out;
    assign ovf       = s3_ovf;

endmodule

// File: tb/tb_fixedpoint_s_pipe.sv
// Bench for fixedpoint_s_pipe: directed corner vectors plus randomized traffic
// scored against an integer-arithmetic reference, on Q4.4->Q8.0 and Q4.4->Q4.4 instances.
module tb_fixedpoint_s_pipe;

    localparam int FRAC_W = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [1:0] mode;
    logic       sat_en;
    logic       out_ready;

    logic       in_ready, out_valid, ovf;
    logic [7:0] out;
    logic       in_ready_q, out_valid_q, ovf_q;
    logic [7:0] out_q;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp0[$];
    logic [8:0] exp1[$];
    logic [7:0] seen[$];
    bit         stall_prev = 1'b0;
    logic [8:0] prev0, prev1;
    bit         stop_rdy;

    always #5 clk = ~clk;

    fixedpoint_s_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .mode(mode), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .ovf(ovf)
    );

    fixedpoint_s_pipe #(.IN_W(8), .FRAC_W(4), .OUT_W(8), .OUT_FRAC(4)) dut_q (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_q),
        .in1(in1), .in2(in2), .mode(mode), .sat_en(sat_en),
        .out_valid(out_valid_q), .out_ready(out_ready), .out(out_q), .ovf(ovf_q)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Exact rational product, floored, then adjusted by the remainder against one half.
    function automatic logic [8:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] m, input logic s, input int of);
        longint p, q, r, rem, scale;
        int sh;
        logic ov;
        logic [7:0] o;
        p  = longint'($signed(a)) * longint'($signed(b));
        sh = 2 * FRAC_W - of;
        if (sh == 0) r = p;
        else begin
            scale = longint'(1) << sh;
            q = p / scale;
            rem = p - q * scale;
            if (rem < 0) begin q = q - 1; rem = rem + scale; end
            if (m == 2'b01 || 2 * rem < scale) r = q;
            else if (2 * rem > scale) r = q + 1;
            else if (m == 2'b10) r = (q % 2 == 0) ? q : q + 1;
            else r = (p > 0) ? q + 1 : q;
        end
        ov = (r > 127) || (r < -128);
        if (ov && s) o = (r > 0) ? 8'h7f : 8'h80;
        else o = r[7:0];
        return {ov, o};
    endfunction

    // Scoreboard: decisions at negedge reflect the transfers of the following posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp0.delete();
            exp1.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_out", {ovf, out}, prev0);
                chk("hold_out_q", {ovf_q, out_q}, prev1);
            end
            if (in_valid && in_ready) begin
                exp0.push_back(ref_mul(in1, in2, mode, sat_en, 0));
                exp1.push_back(ref_mul(in1, in2, mode, sat_en, 4));
            end
            if (out_valid && out_ready) begin
                if (exp0.size() == 0) chk("spurious_out", 1, 0);
                else begin
                    chk("sb_out", {ovf, out}, exp0.pop_front());
                    seen.push_back(out);
                end
            end
            if (out_valid_q && out_ready) begin
                if (exp1.size() == 0) chk("spurious_out_q", 1, 0);
                else chk("sb_out_q", {ovf_q, out_q}, exp1.pop_front());
            end
            stall_prev = out_valid && !out_ready;
            prev0 = {ovf, out};
            prev1 = {ovf_q, out_q};
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m, input logic s);
        int n;
        in1 = a; in2 = b; mode = m; sat_en = s; in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Single beat into an empty pipe with exact latency check on one instance.
    task automatic one_beat(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                            input logic s, input bit q, input logic [7:0] eo, input logic eov);
        in1 = a; in2 = b; mode = m; sat_en = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("lat_c1", q ? out_valid_q : out_valid, 0);
        @(posedge clk); #1;
        chk("lat_c2", q ? out_valid_q : out_valid, 0);
        @(posedge clk); #1;
        chk("lat_c3", q ? out_valid_q : out_valid, 1);
        chk("dir_out", q ? out_q : out, eo);
        chk("dir_ovf", q ? ovf_q : ovf, eov);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; mode = '0; sat_en = 1'b1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_ovf", ovf, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);

        // Rounding corners at OUT_FRAC=0, then saturation corners at OUT_FRAC=4.
        one_beat(8'hf0, 8'hf0, 2'b00, 1'b1, 0, 8'h01, 1'b0);
        one_beat(8'he8, 8'h30, 2'b00, 1'b1, 0, 8'hfb, 1'b0);
        one_beat(8'hec, 8'h30, 2'b00, 1'b1, 0, 8'hfc, 1'b0);
        one_beat(8'he8, 8'h30, 2'b01, 1'b1, 0, 8'hfb, 1'b0);
        one_beat(8'he8, 8'h30, 2'b10, 1'b1, 0, 8'hfc, 1'b0);
        one_beat(8'hec, 8'h30, 2'b01, 1'b1, 0, 8'hfc, 1'b0);
        one_beat(8'he8, 8'h30, 2'b11, 1'b1, 0, 8'hfb, 1'b0);
        one_beat(8'h7f, 8'h7f, 2'b00, 1'b1, 1, 8'h7f, 1'b1);
        one_beat(8'h7f, 8'h7f, 2'b00, 1'b0, 1, 8'hf0, 1'b1);
        one_beat(8'h80, 8'h80, 2'b00, 1'b1, 1, 8'h7f, 1'b1);

        // Back-to-back beats against a toggling, then stalled, downstream.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom));
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    out_ready = (i % 2 == 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b0;
                repeat (5) begin @(posedge clk); #1; end
                chk("full_in_ready", in_ready, 0);
                chk("full_out_valid", out_valid, 1);
                out_ready = 1'b1;
            end
        join
        repeat (6) begin @(posedge clk); #1; end
        chk("stall_drained", exp0.size(), 0);

        // Reset with beats in flight.
        send(8'h11, 8'h22, 2'b00, 1'b1);
        send(8'h33, 8'h44, 2'b01, 1'b0);
        send(8'h55, 8'h66, 2'b10, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_out", out, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("postrst_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("postrst_no_valid", out_valid | out_valid_q, 0);
        end
        @(posedge clk); #1;

        // Valid gaps with the sideband changing every cycle.
        seen.delete();
        for (int c = 0; c < 4; c++) begin
            in1 = 8'he8; in2 = 8'h30; sat_en = 1'b1;
            in_valid = (c == 0 || c == 3);
            case (c)
                0: mode = 2'b00;
                1: mode = 2'b01;
                2: mode = 2'b01;
                default: mode = 2'b10;
            endcase
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        chk("gap_count", seen.size(), 2);
        if (seen.size() >= 2) begin
            chk("gap_beat0", seen[0], 8'hfb);
            chk("gap_beat1", seen[1], 8'hfc);
        end

        // Randomized traffic with random gaps and random backpressure.
        stop_rdy = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom % 4 == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end else
                        send(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom));
                end
                stop_rdy = 1'b1;
            end
            begin
                while (!stop_rdy) begin
                    out_ready = ($urandom % 3) != 0;
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        chk("final_drain", exp0.size(), 0);
        chk("final_drain_q", exp1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
